adc733_frame_ctrl: RTL
======================

ADC733_FRAME_CTRL -- requirements
Module: adc733_frame_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, number of ADC channels per sync frame.
REQ-002 SHALL have parameter CFG_WORDS, default 9: 8 register writes plus 1 data-mode word.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, sample FIFO entries (power of 2).
REQ-004 SHALL have ports, clock and reset first:
- SCLK  in  1  serial-port clock; all logic on rising edge.
- rst_l  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin configuration.
- stop  in  1  one-cycle pulse: abort to IDLE.
- cfg_we  in  1  configuration table write strobe.
- cfg_addr  in  4  table index, 0..CFG_WORDS-1.
- cfg_data  in  16  table word.
- sync_period  in  16  SCLK cycles between sync pulses; 0 disables sync.
- word_sent  in  1  serial port finished one configuration word.
- operation_mode  in  1  serial port is in data mode.
- rd_en  in  1  captured_data/channel valid this cycle.
- channel  in  3  channel index of the current sample.
- captured_data  in  16  ADC sample.
- control_word  out  16  word presented to the serial port.
- sync  out  1  one-cycle frame sync pulse.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  16  sample.
- out_ch  out  3  sample channel.
- out_last  out  1  out_ch == NUM_CH-1.
- cfg_done  out  1  configuration sequence complete.
- overflow  out  1  sticky: sample dropped.
- state_o  out  2  current FSM state.

Function
REQ-005 FSM states SHALL be IDLE=0, CONFIG=1, WAIT_MODE=2, RUN=3.
REQ-006 IDLE: start -> CONFIG; word index cleared to 0; cfg_done, sync cleared.
REQ-007 cfg_we SHALL write cfg_data to table[cfg_addr] only in IDLE with cfg_addr < CFG_WORDS; otherwise it is ignored.
REQ-008 control_word SHALL equal table[index] combinationally in CONFIG; 16'h0000 in all other states.
REQ-009 CONFIG: each word_sent pulse increments the index; the pulse with index == CFG_WORDS-1 -> WAIT_MODE with cfg_done=1.
REQ-010 WAIT_MODE: operation_mode==1 -> RUN next cycle; sync counter cleared.
REQ-011 RUN, sync_period != 0: the counter counts 0..sync_period-1 and wraps; sync=1 for exactly the cycle the counter equals sync_period-1, so the first pulse is sync_period cycles after RUN entry.
REQ-012 RUN, sync_period == 0: sync SHALL stay 0.
REQ-013 In RUN, rd_en SHALL push {channel, captured_data} into the FIFO in the same cycle; rd_en outside RUN is ignored.
REQ-014 Push when full with no pop that cycle SHALL drop the sample and set overflow; with a simultaneous pop, both SHALL succeed.
REQ-015 out_valid = FIFO not empty; pop on out_valid & out_ready; out_data/out_ch/out_last stable while out_valid & !out_ready.
REQ-016 Pop on empty SHALL have no effect.
REQ-017 FIFO latency: a sample pushed at edge N is visible on out_* after edge N.
REQ-018 stop in any state -> IDLE next cycle; FIFO contents retained; sync, cfg_done cleared; overflow cleared only by start.
REQ-019 stop together with start SHALL give IDLE (stop wins).
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 operation_mode falling in RUN SHALL return to WAIT_MODE with sync=0.

Reset
REQ-022 rst_l low SHALL asynchronously force: state IDLE; index, sync counter, FIFO pointers 0; sync, cfg_done, overflow, out_valid 0; table words 16'h0000.

Structure
REQ-023 State encodings and the NUM_CH/CFG_WORDS defaults SHALL live in shared package adc733_pkg.
REQ-024 The sample FIFO SHALL be sub-module adc733_sfifo (19-bit wide, FIFO_DEPTH deep, full/empty flags).

Verification
REQ-025 Table 9 words 16'h8000+i, start, word_sent every 20 cycles -> control_word steps 8000..8008, cfg_done after 9th pulse.
REQ-026 operation_mode=1, sync_period=100 -> sync high at cycles 100, 200, 300 after RUN entry; sync_period=0 -> no sync.
REQ-027 6 rd_en with channel 0..5, data 16'h1000+ch, out_ready=1 -> 6 outputs in order, out_last only on ch 5.
REQ-028 out_ready=0, 9 samples -> 8 held, overflow=1, 9th lost; push with simultaneous pop when full -> no overflow.
REQ-029 stop mid-CONFIG at index 4 -> IDLE next cycle; restart emits from index 0.
REQ-030 rst_l low mid-RUN with FIFO half full -> all outputs at reset values immediately, FIFO empty.

Source files
------------

// File: rtl/adc733_pkg.sv
// Shared definitions for the ADC733 frame controller: FSM encodings, default
// frame geometry and the packed sample format stored in the FIFO.
package adc733_pkg;
  localparam int NUM_CH_DEF    = 6;
  localparam int CFG_WORDS_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CONFIG    = 2'd1,
    ST_WAIT_MODE = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0]  ch;
    logic [15:0] data;
  } sample_t;

  localparam int SAMPLE_W = $bits(sample_t);
endpackage

// File: rtl/adc733_sfifo.sv
// Sample FIFO: fall-through head, push accepted when full only if a pop
// happens in the same cycle. DEPTH must be a power of 2, at least 2.
module adc733_sfifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8
) (
  input  logic             SCLK,
  input  logic             rst_l,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge SCLK) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/adc733_frame_ctrl.sv
// ADC733 frame controller: streams a configuration table to the serial port,
// then generates periodic frame syncs and buffers captured samples.
module adc733_frame_ctrl
  import adc733_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int CFG_WORDS  = CFG_WORDS_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        SCLK,
  input  logic        rst_l,
  input  logic        start,
  input  logic        stop,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic [15:0] sync_period,
  input  logic        word_sent,
  input  logic        operation_mode,
  input  logic        rd_en,
  input  logic [2:0]  channel,
  input  logic [15:0] captured_data,
  output logic [15:0] control_word,
  output logic        sync,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_ch,
  output logic        out_last,
  output logic        cfg_done,
  output logic        overflow,
  output logic [1:0]  state_o
);
  localparam logic [3:0] LAST_IDX = 4'(CFG_WORDS - 1);
  localparam logic [2:0] LAST_CH  = 3'(NUM_CH - 1);

  state_t        state;
  logic [3:0]    idx;
  logic [15:0]   cnt;
  logic [15:0]   tbl [CFG_WORDS];
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  sample_t       head, in_smp;

  assign state_o      = state;
  assign control_word = (state == ST_CONFIG) ? tbl[idx] : 16'h0000;

  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < CFG_WORDS; i++) tbl[i] <= 16'h0000;
    end else if (state == ST_IDLE && cfg_we && cfg_addr <= LAST_IDX) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // stop has priority over every other transition, including start in IDLE.
  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) begin
      state    <= ST_IDLE;
      idx      <= '0;
      cnt      <= '0;
      sync     <= 1'b0;
      cfg_done <= 1'b0;
    end else if (stop) begin
      state    <= ST_IDLE;
      sync     <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      sync <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state    <= ST_CONFIG;
          idx      <= '0;
          cfg_done <= 1'b0;
        end
        ST_CONFIG: if (word_sent) begin
          if (idx == LAST_IDX) begin
            state    <= ST_WAIT_MODE;
            cfg_done <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        ST_WAIT_MODE: if (operation_mode) begin
          state <= ST_RUN;
          cnt   <= '0;
        end
        ST_RUN: begin
          if (!operation_mode) begin
            state <= ST_WAIT_MODE;
          end else if (sync_period != 16'd0) begin
            // Pulse lands sync_period edges after RUN entry, then every period.
            if (cnt >= sync_period - 16'd1) begin
              cnt  <= '0;
              sync <= 1'b1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_push = rd_en && (state == ST_RUN);
  assign fifo_pop  = out_valid && out_ready;
  assign in_smp    = '{ch: channel, data: captured_data};

  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l)                               overflow <= 1'b0;
    else if (state == ST_IDLE && start && !stop) overflow <= 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
  end

  adc733_sfifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_sfifo (
    .SCLK  (SCLK),
    .rst_l (rst_l),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_smp),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head.data : 16'h0000;
  assign out_ch    = out_valid ? head.ch   : 3'd0;
  assign out_last  = out_valid && (head.ch == LAST_CH);
endmodule
